// File: rtl/blast_ctrl_pkg.sv
// Shared game definitions: blast FSM states, visible screen limits and the
// clamping helpers used by the bomb placer, blast controller and drawing logic.
package blast_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FUSE  = 2'd1,
      BLAST = 2'd2,
      COOL  = 2'd3
   } blast_state_t;

   localparam logic [9:0] SCREEN_X_MAX = 10'd639;
   localparam logic [9:0] SCREEN_Y_MAX = 10'd479;

   // Lower extent of an arm, floored at the screen edge instead of wrapping.
   function automatic logic [9:0] ext_lo(input logic [9:0] c, input logic [10:0] r);
      logic [10:0] c11;
      c11 = {1'b0, c};
      return (c11 < r) ? 10'd0 : 10'(c11 - r);
   endfunction

   function automatic logic [9:0] ext_hi(input logic [9:0] c, input logic [10:0] r,
                                         input logic [9:0] lim);
      logic [10:0] sum;
      sum = {1'b0, c} + r;
      return (sum > {1'b0, lim}) ? lim : sum[9:0];
   endfunction

   function automatic logic [10:0] abs_diff11(input logic [9:0] a, input logic [9:0] b);
      logic [10:0] a11;
      logic [10:0] b11;
      a11 = {1'b0, a};
      b11 = {1'b0, b};
      return (a11 >= b11) ? (a11 - b11) : (b11 - a11);
   endfunction

endpackage

// File: rtl/blast_ctrl_region.sv
// Blast cross geometry: clamped extents around a centre and the player hit test
// against the registered extents of the active blast.
module blast_region
   import blast_ctrl_pkg::*;
#(
   parameter int BLAST_R  = 32,
   parameter int BLAST_HW = 4
) (
   input  logic [9:0] center_x,
   input  logic [9:0] center_y,
   input  logic [9:0] xmin_i,
   input  logic [9:0] xmax_i,
   input  logic [9:0] ymin_i,
   input  logic [9:0] ymax_i,
   input  logic [9:0] user_x,
   input  logic [9:0] user_y,
   input  logic       blast_on,
   output logic [9:0] xmin_o,
   output logic [9:0] xmax_o,
   output logic [9:0] ymin_o,
   output logic [9:0] ymax_o,
   output logic       player_hit
);

   localparam logic [10:0] R11  = 11'(BLAST_R);
   localparam logic [10:0] HW11 = 11'(BLAST_HW);

   logic [10:0] dx;
   logic [10:0] dy;
   logic        h_arm;
   logic        v_arm;

   always_comb begin
      xmin_o = ext_lo(center_x, R11);
      xmax_o = ext_hi(center_x, R11, SCREEN_X_MAX);
      ymin_o = ext_lo(center_y, R11);
      ymax_o = ext_hi(center_y, R11, SCREEN_Y_MAX);
   end

   // Distances are taken in 11 bits so a player left of / above the centre
   // does not wrap into a huge positive offset.
   always_comb begin
      dx         = abs_diff11(user_x, center_x);
      dy         = abs_diff11(user_y, center_y);
      h_arm      = (user_x >= xmin_i) && (user_x <= xmax_i) && (dy <= HW11);
      v_arm      = (user_y >= ymin_i) && (user_y <= ymax_i) && (dx <= HW11);
      player_hit = blast_on && (h_arm || v_arm);
   end

endmodule

// File: rtl/blast_ctrl.sv
// Bomb lifecycle controller: fuse countdown, blast window and cool-down, with
// the blast centre and extents latched for the drawing and hit logic.
module blast_ctrl
   import blast_ctrl_pkg::*;
#(
   parameter int FUSE_FRAMES  = 120,
   parameter int BLAST_FRAMES = 30,
   parameter int COOL_FRAMES  = 15,
   parameter int BLAST_R      = 32,
   parameter int BLAST_HW     = 4
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       bomb_check,
   input  logic [9:0] bombX,
   input  logic [9:0] bombY,
   input  logic       detonate,
   input  logic [9:0] userX,
   input  logic [9:0] userY,
   output logic       explode,
   output logic       blast_on,
   output logic [9:0] blast_xmin,
   output logic [9:0] blast_xmax,
   output logic [9:0] blast_ymin,
   output logic [9:0] blast_ymax,
   output logic [9:0] blastX,
   output logic [9:0] blastY,
   output logic       player_hit,
   output logic [7:0] fuse_left
);

   blast_state_t state_q, state_d;
   logic [7:0]   cnt_q, cnt_d;
   logic         explode_q, explode_d;
   logic [9:0]   bx_q, bx_d;
   logic [9:0]   by_q, by_d;
   logic [9:0]   xmin_q, xmin_d;
   logic [9:0]   xmax_q, xmax_d;
   logic [9:0]   ymin_q, ymin_d;
   logic [9:0]   ymax_q, ymax_d;
   logic [9:0]   xmin_c, xmax_c, ymin_c, ymax_c;
   logic         bomb_on_screen;

   blast_region #(
      .BLAST_R  (BLAST_R),
      .BLAST_HW (BLAST_HW)
   ) u_region (
      .center_x   (bx_q),
      .center_y   (by_q),
      .xmin_i     (xmin_q),
      .xmax_i     (xmax_q),
      .ymin_i     (ymin_q),
      .ymax_i     (ymax_q),
      .user_x     (userX),
      .user_y     (userY),
      .blast_on   (blast_on),
      .xmin_o     (xmin_c),
      .xmax_o     (xmax_c),
      .ymin_o     (ymin_c),
      .ymax_o     (ymax_c),
      .player_hit (player_hit)
   );

   assign bomb_on_screen = (bombX <= SCREEN_X_MAX) && (bombY <= SCREEN_Y_MAX);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      explode_d = 1'b0;
      bx_d      = bx_q;
      by_d      = by_q;
      xmin_d    = xmin_q;
      xmax_d    = xmax_q;
      ymin_d    = ymin_q;
      ymax_d    = ymax_q;
      case (state_q)
         IDLE: begin
            if (bomb_check && bomb_on_screen) begin
               state_d = FUSE;
               cnt_d   = 8'(FUSE_FRAMES);
               bx_d    = bombX;
               by_d    = bombY;
            end
         end
         FUSE: begin
            // An early detonate wins over a simultaneous bomb removal.
            if (detonate || (bomb_check && cnt_q == 8'd1)) begin
               state_d   = BLAST;
               cnt_d     = 8'(BLAST_FRAMES);
               explode_d = 1'b1;
               xmin_d    = xmin_c;
               xmax_d    = xmax_c;
               ymin_d    = ymin_c;
               ymax_d    = ymax_c;
            end else if (!bomb_check) begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         BLAST: begin
            if (cnt_q == 8'd1) begin
               state_d = COOL;
               cnt_d   = 8'(COOL_FRAMES);
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         COOL: begin
            if (cnt_q == 8'd1) begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         explode_q <= 1'b0;
         bx_q      <= 10'd0;
         by_q      <= 10'd0;
         xmin_q    <= 10'd0;
         xmax_q    <= 10'd0;
         ymin_q    <= 10'd0;
         ymax_q    <= 10'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         explode_q <= explode_d;
         bx_q      <= bx_d;
         by_q      <= by_d;
         xmin_q    <= xmin_d;
         xmax_q    <= xmax_d;
         ymin_q    <= ymin_d;
         ymax_q    <= ymax_d;
      end
   end

   assign explode    = explode_q;
   assign blast_on   = (state_q == BLAST);
   assign fuse_left  = (state_q == FUSE) ? cnt_q : 8'd0;
   assign blastX     = bx_q;
   assign blastY     = by_q;
   assign blast_xmin = xmin_q;
   assign blast_xmax = xmax_q;
   assign blast_ymin = ymin_q;
   assign blast_ymax = ymax_q;

endmodule

// File: tb/tb_blast_ctrl.sv
// Self-checking bench for blast_ctrl: directed bomb lifecycles with a scoreboard
// of expected explode frames and blast extents.
module tb_blast_ctrl;

   localparam int W = 56;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic       bomb_check;
   logic [9:0] bombX, bombY;
   logic       detonate;
   logic [9:0] userX, userY;
   logic       explode, blast_on, player_hit;
   logic [9:0] blast_xmin, blast_xmax, blast_ymin, blast_ymax;
   logic [9:0] blastX, blastY;
   logic [7:0] fuse_left;

   logic [15:0]  frame_no = 16'd0;
   logic [W-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   blast_ctrl #(
      .FUSE_FRAMES  (120),
      .BLAST_FRAMES (30),
      .COOL_FRAMES  (15),
      .BLAST_R      (32),
      .BLAST_HW     (4)
   ) dut (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .bomb_check (bomb_check),
      .bombX      (bombX),
      .bombY      (bombY),
      .detonate   (detonate),
      .userX      (userX),
      .userY      (userY),
      .explode    (explode),
      .blast_on   (blast_on),
      .blast_xmin (blast_xmin),
      .blast_xmax (blast_xmax),
      .blast_ymin (blast_ymin),
      .blast_ymax (blast_ymax),
      .blastX     (blastX),
      .blastY     (blastY),
      .player_hit (player_hit),
      .fuse_left  (fuse_left)
   );

   // clock / reset
   always #5 frame_clk = ~frame_clk;
   always @(posedge frame_clk) frame_no <= frame_no + 16'd1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic step(input int n);
      repeat (n) begin
         @(posedge frame_clk);
         #1;
      end
   endtask

   task automatic push_exp(input logic [15:0] f, input logic [9:0] x0, input logic [9:0] x1,
                           input logic [9:0] y0, input logic [9:0] y1);
      exp_q.push_back({f, x0, x1, y0, y1});
   endtask

   task automatic wait_explode(input string tag);
      int n = 0;
      while (!explode && n < 300) begin
         step(1);
         n++;
      end
      if (!explode) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
         exp_q.delete();
      end
   endtask

   task automatic wait_fuse(input logic [7:0] v);
      int n = 0;
      while (fuse_left != v && n < 300) begin
         step(1);
         n++;
      end
      if (fuse_left != v) check("fuse_wait_timeout", 32'(fuse_left), 32'(v));
   endtask

   task automatic count_blast(output int n);
      n = 0;
      while (blast_on && n < 100) begin
         n++;
         step(1);
      end
   endtask

   // scoreboard: every explode pulse must match the oldest expectation
   always @(negedge frame_clk) begin
      logic [W-1:0] e;
      if (explode) begin
         if (exp_q.size() == 0) begin
            check("explode_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("exp_frame", 32'(frame_no),   32'(e[55:40]));
            check("exp_xmin",  32'(blast_xmin), 32'(e[39:30]));
            check("exp_xmax",  32'(blast_xmax), 32'(e[29:20]));
            check("exp_ymin",  32'(blast_ymin), 32'(e[19:10]));
            check("exp_ymax",  32'(blast_ymax), 32'(e[9:0]));
         end
      end
   end

   int hx[8] = '{100, 120, 132, 133, 100, 104, 105,  68};
   int hy[8] = '{128, 120, 104, 100, 133,  68,  68,  96};
   int he[8] = '{  1,   0,   1,   0,   0,   1,   0,   1};

   task automatic check_all_zero(input string tag);
      check({tag, "_explode"},  32'(explode),    32'd0);
      check({tag, "_blast_on"}, 32'(blast_on),   32'd0);
      check({tag, "_hit"},      32'(player_hit), 32'd0);
      check({tag, "_fuse"},     32'(fuse_left),  32'd0);
      check({tag, "_bx"},       32'(blastX),     32'd0);
      check({tag, "_by"},       32'(blastY),     32'd0);
      check({tag, "_xmin"},     32'(blast_xmin), 32'd0);
      check({tag, "_xmax"},     32'(blast_xmax), 32'd0);
      check({tag, "_ymin"},     32'(blast_ymin), 32'd0);
      check({tag, "_ymax"},     32'(blast_ymax), 32'd0);
   endtask

   initial begin
      int n;
      Reset = 1'b1; bomb_check = 1'b0; bombX = '0; bombY = '0;
      detonate = 1'b0; userX = '0; userY = '0;
      step(2);
      check_all_zero("rst");
      Reset = 1'b0;
      step(1);

      // natural fuse at (100,100)
      bomb_check = 1'b1; bombX = 10'd100; bombY = 10'd100;
      step(1);
      check("arm_fuse", 32'(fuse_left), 32'd120);
      check("arm_bx", 32'(blastX), 32'd100);
      push_exp(frame_no + 16'd120, 10'd68, 10'd132, 10'd68, 10'd132);
      wait_explode("nat");
      bomb_check = 1'b0;
      count_blast(n);
      check("nat_blast_len", 32'(n), 32'd30);

      // re-arm held through cool-down: 15 cool frames, then the idle frame arms
      bomb_check = 1'b1; bombX = 10'd200; bombY = 10'd200;
      n = 0;
      while (fuse_left == 8'd0 && n < 100) begin
         step(1);
         n++;
      end
      check("cool_refuse", 32'(n), 32'd16);
      check("rearm_fuse", 32'(fuse_left), 32'd120);

      // early detonate at fuse_left = 50
      wait_fuse(8'd50);
      detonate = 1'b1;
      push_exp(frame_no + 16'd1, 10'd168, 10'd232, 10'd168, 10'd232);
      step(1);
      detonate = 1'b0;
      check("det_explode", 32'(explode), 32'd1);
      bomb_check = 1'b0;
      count_blast(n);
      check("det_blast_len", 32'(n), 32'd30);
      step(20);

      // hit pattern at (100,100), then reset on blast frame 10
      bomb_check = 1'b1; bombX = 10'd100; bombY = 10'd100;
      step(1);
      detonate = 1'b1;
      push_exp(frame_no + 16'd1, 10'd68, 10'd132, 10'd68, 10'd132);
      step(1);
      detonate = 1'b0; bomb_check = 1'b0;
      for (int i = 0; i < 8; i++) begin
         userX = 10'(hx[i]); userY = 10'(hy[i]);
         #1;
         check($sformatf("hit_%0d_%0d", hx[i], hy[i]), 32'(player_hit), 32'(he[i]));
      end
      step(9);
      check("b10_blast_on", 32'(blast_on), 32'd1);
      userX = 10'd100; userY = 10'd100;
      #1;
      check("b10_hit", 32'(player_hit), 32'd1);
      Reset = 1'b1;
      #1;
      check_all_zero("midrst");
      step(1);
      Reset = 1'b0;
      step(1);
      check("post_rst_idle", 32'(fuse_left), 32'd0);
      bomb_check = 1'b1; bombX = 10'd300; bombY = 10'd300;
      step(1);
      check("post_rst_arm", 32'(fuse_left), 32'd120);
      check("post_rst_bx", 32'(blastX), 32'd300);

      // player never hit outside a blast
      for (int i = 0; i < 4; i++) begin
         userX = 10'($urandom_range(0, 639)); userY = 10'($urandom_range(0, 479));
         #1;
         check("fuse_no_hit", 32'(player_hit), 32'd0);
      end

      // bomb removed mid-fuse: abort, no explode
      wait_fuse(8'd60);
      bomb_check = 1'b0;
      step(1);
      check("abort_fuse", 32'(fuse_left), 32'd0);
      check("abort_blast", 32'(blast_on), 32'd0);
      step(130);
      check("abort_quiet", 32'(blast_on), 32'd0);

      // off-screen placements are ignored
      bomb_check = 1'b1; bombX = 10'd700; bombY = 10'd500;
      step(3);
      check("off_xy_idle", 32'(fuse_left), 32'd0);
      bombX = 10'd100; bombY = 10'd480;
      step(2);
      check("off_y_idle", 32'(fuse_left), 32'd0);

      // clamped corner (10,470)
      bombX = 10'd10; bombY = 10'd470;
      step(1);
      check("corner_fuse", 32'(fuse_left), 32'd120);
      check("corner_by", 32'(blastY), 32'd470);
      detonate = 1'b1;
      push_exp(frame_no + 16'd1, 10'd0, 10'd42, 10'd438, 10'd479);
      step(1);
      detonate = 1'b0; bomb_check = 1'b0;
      userX = 10'd0; userY = 10'd470;
      #1;
      check("corner_hit_h", 32'(player_hit), 32'd1);
      userX = 10'd43;
      #1;
      check("corner_miss", 32'(player_hit), 32'd0);
      userX = 10'd10; userY = 10'd479;
      #1;
      check("corner_hit_v", 32'(player_hit), 32'd1);
      step(50);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/blast_ctrl.md
BLAST_CTRL -- requirements
Module: blast_ctrl

Interface
REQ-001 Parameter FUSE_FRAMES, default 120, frames from arming to detonation (range 1..255).
REQ-002 Parameter BLAST_FRAMES, default 30, frames the blast stays active (range 1..255).
REQ-003 Parameter COOL_FRAMES, default 15, frames after the blast before re-arming is allowed (range 1..255).
REQ-004 Parameter BLAST_R, default 32, blast arm length in pixels from the bomb centre.
REQ-005 Parameter BLAST_HW, default 4, blast arm half-width in pixels.
REQ-006 Port frame_clk, input, 1, single clock for all state; one edge per video frame.
REQ-007 Port Reset, input, 1, asynchronous active-high reset.
REQ-008 Port bomb_check, input, 1, bomb placed and live, from the bomb placer.
REQ-009 Port bombX / bombY, input, 10 each, bomb centre position.
REQ-010 Port detonate, input, 1, early-detonation request.
REQ-011 Port userX / userY, input, 10 each, player centre position.
REQ-012 Port explode, output, 1, one-frame pulse that tells the placer to clear the bomb.
REQ-013 Port blast_on, output, 1, high while the blast is drawn and harmful.
REQ-014 Port blast_xmin / blast_xmax / blast_ymin / blast_ymax, output, 10 each, clamped blast extents.
REQ-015 Port blastX / blastY, output, 10 each, latched blast centre.
REQ-016 Port player_hit, output, 1, player inside the blast cross.
REQ-017 Port fuse_left, output, 8, frames remaining in the fuse; 0 outside FUSE.

Function
REQ-018 States: IDLE, FUSE, BLAST, COOL; one shared 8-bit frame counter.
- Transitions are evaluated on the posedge of frame_clk.
REQ-019 IDLE -> FUSE when bomb_check=1, bombX<=639 and bombY<=479.
- On that transition: latch bombX/bombY into blastX/blastY and load counter=FUSE_FRAMES.
- Off-screen coordinates (for example 700/500) are ignored and the block stays in IDLE.
REQ-020 In FUSE the counter decrements each frame.
- FUSE -> BLAST when counter reaches 1 or detonate=1.
- So detonation occurs exactly FUSE_FRAMES frames after arming, or on the frame after detonate.
REQ-021 explode SHALL be 1 for exactly the one frame following the FUSE->BLAST edge, and 0 at all other times.
REQ-022 FUSE->BLAST loads counter=BLAST_FRAMES.
- BLAST -> COOL when counter reaches 1; COOL loads counter=COOL_FRAMES.
- COOL -> IDLE when counter reaches 1.
REQ-023 In FUSE, if bomb_check falls with detonate=0, the fuse aborts: go to IDLE, no explode, no blast.
REQ-024 detonate is ignored in IDLE, BLAST and COOL.
- In COOL, bomb_check=1 does not arm; it is evaluated only in IDLE.
REQ-025 blast_on SHALL equal (state==BLAST); fuse_left = counter in FUSE, else 0.
REQ-026 Extents are computed in 11 bits and registered on entry to BLAST:
- xmin = blastX<BLAST_R ? 0 : blastX-BLAST_R
- xmax = min(blastX+BLAST_R, 639)
- ymin / ymax computed likewise, with ymax clamped at 479.
REQ-027 player_hit is combinational and asserts when blast_on=1 and either:
- horizontal arm: userX in [xmin,xmax] and |userY-blastY|<=BLAST_HW, or
- vertical arm: userY in [ymin,ymax] and |userX-blastX|<=BLAST_HW.
- Subtractions are done without 10-bit wrap.

Reset
REQ-028 Reset SHALL force state IDLE, counter 0, explode 0, blast_on 0 and player_hit 0.
REQ-029 Reset SHALL clear blastX, blastY, all extents and fuse_left to 0.
REQ-030 Reset asserted mid-FUSE or mid-BLAST SHALL abort immediately with no explode pulse.
- After release the block re-arms only via REQ-019.

Structure
REQ-031 The state enum (IDLE/FUSE/BLAST/COOL) and the screen limits 639/479 SHALL live in a shared game package, also used by the placer and the drawing logic.
REQ-032 The extent clamp plus hit test SHALL be one sub-module, blast_region, instantiated once.

Verification
REQ-033 Arm at (100,100), FUSE_FRAMES=120 -> explode pulses exactly 120 frames after arming; extents 68/132/68/132; blast_on for 30 frames; re-arm refused for 15 frames.
REQ-034 Arm at (10,470) -> xmin=0, xmax=42, ymin=438, ymax=479.
REQ-035 detonate at fuse_left=50 -> explode on the next frame, then BLAST for 30 frames.
REQ-036 Blast at (100,100): user (100,128) -> hit=1; user (120,120) -> hit=0; user (132,104) -> hit=1.
REQ-037 Reset pulsed on BLAST frame 10 -> all outputs 0 at once; bomb_check=1 afterwards -> re-arms with a new FUSE.
REQ-038 bomb_check drops at fuse_left=60 -> IDLE with no explode; bombX=700 with bomb_check=1 -> stays IDLE.
